// File: rtl/tri_sum_decoder.sv
// Triangular-sum decoder: finds the largest n with n(n+1)/2 <= value by
// subtracting 1, 2, 3, ... from the value until the next term no longer fits.
module tri_sum_decoder (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [5:0] value,
   output logic       busy,
   output logic       done,
   output logic [3:0] n,
   output logic [5:0] rem,
   output logic       exact
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] r_q, r_d;
   logic [3:0] b_q, b_d;
   logic [3:0] c_q, c_d;
   logic [3:0] n_q, n_d;
   logic [5:0] rem_q, rem_d;
   logic       exact_q, exact_d;
   logic       termFits;

   // The compare guards the subtraction, so the remainder never underflows.
   assign termFits = (r_q >= {2'b00, b_q});

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      b_d     = b_q;
      c_d     = c_q;
      n_d     = n_q;
      rem_d   = rem_q;
      exact_d = exact_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               r_d     = value;
               b_d     = 4'd1;
               c_d     = 4'd0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (termFits) begin
               r_d = r_q - {2'b00, b_q};
               b_d = b_q + 4'd1;
               c_d = c_q + 4'd1;
            end else begin
               n_d     = c_q;
               rem_d   = r_q;
               exact_d = (r_q == 6'd0);
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Reset leaves the results looking like a decode of value 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         r_q     <= 6'd0;
         b_q     <= 4'd0;
         c_q     <= 4'd0;
         n_q     <= 4'd0;
         rem_q   <= 6'd0;
         exact_q <= 1'b1;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         b_q     <= b_d;
         c_q     <= c_d;
         n_q     <= n_d;
         rem_q   <= rem_d;
         exact_q <= exact_d;
      end
   end

   assign busy  = (state_q != IDLE);
   assign done  = (state_q == DONE);
   assign n     = n_q;
   assign rem   = rem_q;
   assign exact = exact_q;

endmodule
